// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the LSU response path
package lsu_pkg;

    localparam int LSU_OFF_W = 2;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_type_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT1,
        WAIT2,
        HOLD
    } lsu_out_state_e;

    // An access crosses a word boundary and needs a second beat at addr+4.
    function automatic logic is_misaligned(lsu_type_e ty, logic [LSU_OFF_W-1:0] off);
        return ((ty == LSU_WORD) && (off != '0)) || ((ty == LSU_HALF) && (off == 2'd3));
    endfunction

endpackage

// File: rtl/lsu_rdata_align.sv
// rtl/lsu_rdata_align.sv - shift, mask and extend a {hi,lo} beat pair into load data
module lsu_rdata_align
    import lsu_pkg::*;
(
    input  logic [31:0]          hi,
    input  logic [31:0]          lo,
    input  logic [LSU_OFF_W-1:0] off,
    input  lsu_type_e            ty,
    input  logic                 sext,
    output logic [31:0]          data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = {hi, lo} >> {off, 3'b000};
        case (ty)
            LSU_BYTE: data = {{24{sext & shifted[7]}}, shifted[7:0]};
            LSU_HALF: data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default:  data = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/lsu_out.sv
// rtl/lsu_out.sv - LSU response capture/align/hold stage; LSU_OUT_MISALIGNED_EN enables two-beat accesses
module lsu_out
    import lsu_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [1:0]           type_i,
    input  logic                 sign_ext_i,
    input  logic [LSU_OFF_W-1:0] addr_lo_i,
    input  logic                 data_rvalid_i,
    input  logic [DW-1:0]        data_rdata_i,
    input  logic                 data_err_i,
    input  logic                 wb_ready_i,
    output logic                 lsu_rvalid_o,
    output logic [DW-1:0]        lsu_rdata_o,
    output logic                 lsu_err_o,
    output logic                 split_o,
    output logic                 busy_o
);

    lsu_out_state_e       state_q;
    logic                 we_q;
    lsu_type_e            ty_q;
    logic                 sext_q;
    logic [LSU_OFF_W-1:0] off_q;
    logic                 mis_q;
    logic                 rvalid_q;
    logic [31:0]          rdata_q;
    logic                 err_q;
    logic [31:0]          align_hi;
    logic [31:0]          align_lo;
    logic [31:0]          aligned;

`ifdef LSU_OUT_MISALIGNED_EN
    logic [31:0] beat_lo_q;
    logic        split_q;

    // In WAIT2 the live beat is the upper word; the buffered first beat is the lower.
    assign align_hi = (state_q == WAIT2) ? data_rdata_i : 32'h0;
    assign align_lo = (state_q == WAIT2) ? beat_lo_q : data_rdata_i;
    assign split_o  = split_q;
`else
    assign align_hi = 32'h0;
    assign align_lo = data_rdata_i;
    assign split_o  = 1'b0;
`endif

    lsu_rdata_align u_align (
        .hi   (align_hi),
        .lo   (align_lo),
        .off  (off_q),
        .ty   (ty_q),
        .sext (sext_q),
        .data (aligned)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            ty_q     <= LSU_WORD;
            sext_q   <= 1'b0;
            off_q    <= '0;
            mis_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
`ifdef LSU_OUT_MISALIGNED_EN
            beat_lo_q <= 32'h0;
            split_q   <= 1'b0;
`endif
        end else begin
`ifdef LSU_OUT_MISALIGNED_EN
            split_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        ty_q    <= lsu_type_e'(type_i);
                        sext_q  <= sign_ext_i;
                        off_q   <= addr_lo_i;
                        mis_q   <= is_misaligned(lsu_type_e'(type_i), addr_lo_i);
                        state_q <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) begin
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                            rdata_q  <= 32'h0;
                            state_q  <= HOLD;
                        end else if (mis_q) begin
`ifdef LSU_OUT_MISALIGNED_EN
                            beat_lo_q <= data_rdata_i;
                            split_q   <= 1'b1;
                            state_q   <= WAIT2;
`else
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                            rdata_q  <= 32'h0;
                            state_q  <= HOLD;
`endif
                        end else begin
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b0;
                            rdata_q  <= we_q ? 32'h0 : aligned;
                            state_q  <= HOLD;
                        end
                    end
                end
                WAIT2: begin
                    if (data_rvalid_i) begin
                        rvalid_q <= 1'b1;
                        err_q    <= data_err_i;
                        rdata_q  <= (we_q || data_err_i) ? 32'h0 : aligned;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (wb_ready_i) begin
                        rvalid_q <= 1'b0;
                        err_q    <= 1'b0;
                        rdata_q  <= 32'h0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lsu_rvalid_o = rvalid_q;
    assign lsu_rdata_o  = rdata_q;
    assign lsu_err_o    = err_q;
    assign busy_o       = (state_q != IDLE);

endmodule
